// File: rtl/fetch_control.sv
// Fetch-unit sequencing control: decodes jumps, memory ops and system calls and steers PC update.
// Latency: all control outputs are combinational from state and inputs; state and io_instret update on the clock edge.
// Backpressure: loads/stores stall fetch until io_mem_ready, or until a MEM_TIMEOUT-cycle abort skips the instruction.
module fetch_control #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] io_instr,
  input  logic        io_instr_valid,
  input  logic [31:0] io_rs1_data,
  input  logic        io_mem_ready,
  output logic [31:0] io_imm,
  output logic [31:0] io_rs1,
  output logic        io_jal_en,
  output logic        io_jalr_en,
  output logic        io_stall_en,
  output logic        io_mem_req,
  output logic        io_mem_err,
  output logic        io_halted,
  output logic [31:0] io_instret
);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_HALT     = 2'd2
  } state_t;

  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_SYS   = 7'b1110011;
  localparam logic [3:0] TIMEOUT_LAST = 4'(MEM_TIMEOUT - 1);

  state_t      r_state;
  logic [3:0]  r_wait_cnt;
  logic [31:0] r_instret;

  state_t      w_next_state;
  logic [3:0]  w_next_cnt;
  logic        w_retire;
  logic        w_is_jal;
  logic        w_is_jalr;
  logic        w_is_mem;
  logic        w_is_sys;
  logic        w_unused_rd;

  // rd is not needed for PC sequencing
  assign w_unused_rd = ^io_instr[11:7];

  assign w_is_jal  = (io_instr[6:0] == OP_JAL);
  assign w_is_jalr = (io_instr[6:0] == OP_JALR);
  assign w_is_mem  = (io_instr[6:0] == OP_LOAD) || (io_instr[6:0] == OP_STORE);
  assign w_is_sys  = (io_instr[6:0] == OP_SYS) && (io_instr[14:12] == 3'b000);

  assign io_rs1     = io_rs1_data;
  assign io_instret = r_instret;
  assign io_halted  = (r_state == S_HALT) && !reset;

  // Immediate for the jump target adder; JALR LSB is deliberately kept (target = rs1 + imm)
  always_comb begin
    io_imm = 32'd0;
    if (w_is_jal) begin
      io_imm = {{12{io_instr[31]}}, io_instr[19:12], io_instr[20], io_instr[30:21], 1'b0};
    end else if (w_is_jalr) begin
      io_imm = {{20{io_instr[31]}}, io_instr[31:20]};
    end
  end

  // Control decode and next-state selection; reset overrides everything to a safe stall
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_wait_cnt;
    w_retire     = 1'b0;
    io_jal_en    = 1'b0;
    io_jalr_en   = 1'b0;
    io_stall_en  = 1'b0;
    io_mem_req   = 1'b0;
    io_mem_err   = 1'b0;
    case (r_state)
      S_RUN: begin
        if (!io_instr_valid) begin
          io_stall_en = 1'b1;
        end else if (w_is_jal) begin
          io_jal_en = 1'b1;
          w_retire  = 1'b1;
        end else if (w_is_jalr) begin
          io_jalr_en = 1'b1;
          w_retire   = 1'b1;
        end else if (w_is_mem) begin
          io_mem_req   = 1'b1;
          io_stall_en  = 1'b1;
          w_next_state = S_MEM_WAIT;
          w_next_cnt   = 4'd0;
        end else if (w_is_sys) begin
          io_stall_en  = 1'b1;
          w_next_state = S_HALT;
        end else begin
          w_retire = 1'b1;
        end
      end
      S_MEM_WAIT: begin
        // completion wins over a coincident timeout
        if (io_mem_ready) begin
          w_retire     = 1'b1;
          w_next_state = S_RUN;
        end else if (r_wait_cnt == TIMEOUT_LAST) begin
          io_mem_err   = 1'b1;
          w_next_state = S_RUN;
        end else begin
          io_stall_en = 1'b1;
          w_next_cnt  = r_wait_cnt + 4'd1;
        end
      end
      S_HALT: begin
        io_stall_en = 1'b1;
      end
      default: begin
        io_stall_en  = 1'b1;
        w_next_state = S_RUN;
      end
    endcase
    if (reset) begin
      w_retire    = 1'b0;
      io_jal_en   = 1'b0;
      io_jalr_en  = 1'b0;
      io_stall_en = 1'b1;
      io_mem_req  = 1'b0;
      io_mem_err  = 1'b0;
    end
  end

  // State, wait counter and retired-instruction counter
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_RUN;
      r_wait_cnt <= 4'd0;
      r_instret  <= 32'd0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_next_cnt;
      if (w_retire) begin
        r_instret <= r_instret + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_control.sv
// Scoreboard bench for fetch_control: each row drives one cycle and queues the expected outputs.
// Expected values come from the hand-written rows plus a running retire count kept by the bench.
// Outputs are sampled on the falling edge, inputs change 1 time unit after the rising edge.
module tb_fetch_control;

  logic        clock;
  logic        reset;
  logic [31:0] io_instr;
  logic        io_instr_valid;
  logic [31:0] io_rs1_data;
  logic        io_mem_ready;
  logic [31:0] io_imm;
  logic [31:0] io_rs1;
  logic        io_jal_en;
  logic        io_jalr_en;
  logic        io_stall_en;
  logic        io_mem_req;
  logic        io_mem_err;
  logic        io_halted;
  logic [31:0] io_instret;

  fetch_control #(.MEM_TIMEOUT(15)) dut (
    .clock          (clock),
    .reset          (reset),
    .io_instr       (io_instr),
    .io_instr_valid (io_instr_valid),
    .io_rs1_data    (io_rs1_data),
    .io_mem_ready   (io_mem_ready),
    .io_imm         (io_imm),
    .io_rs1         (io_rs1),
    .io_jal_en      (io_jal_en),
    .io_jalr_en     (io_jalr_en),
    .io_stall_en    (io_stall_en),
    .io_mem_req     (io_mem_req),
    .io_mem_err     (io_mem_err),
    .io_halted      (io_halted),
    .io_instret     (io_instret)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // control vector order: {stall, jal, jalr, mem_req, mem_err, halted}
  localparam logic [5:0] C_NONE  = 6'b000000;
  localparam logic [5:0] C_STALL = 6'b100000;
  localparam logic [5:0] C_JAL   = 6'b010000;
  localparam logic [5:0] C_JALR  = 6'b001000;
  localparam logic [5:0] C_REQ   = 6'b000100;
  localparam logic [5:0] C_ERR   = 6'b000010;
  localparam logic [5:0] C_HALT  = 6'b000001;

  localparam logic [31:0] ADDI   = 32'h0010_0093;
  localparam logic [31:0] CSRRW  = 32'h3000_1073;
  localparam logic [31:0] JAL8   = 32'h0080_006F;
  localparam logic [31:0] JALM4  = 32'hFFDF_F06F;
  localparam logic [31:0] JALR   = 32'hFFC0_8067;
  localparam logic [31:0] JALR1  = 32'h0010_8067;
  localparam logic [31:0] LW     = 32'h0001_2083;
  localparam logic [31:0] SW     = 32'h0011_2023;
  localparam logic [31:0] ECALL  = 32'h0000_0073;

  typedef struct packed {
    logic [31:0] instr;
    logic        valid;
    logic [31:0] rs1;
    logic        ready;
    logic        rst;
    logic [5:0]  ctl;
    logic [31:0] imm;
    logic        ret;
  } row_t;

  typedef struct packed {
    logic [5:0]  ctl;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] instret;
  } obs_t;

  obs_t        exp_q[$];
  logic [31:0] m_instret;
  int          n_cmp;
  int          n_err;

  function automatic row_t mk(input logic [31:0] instr, input logic valid, input logic [31:0] rs1,
                              input logic ready, input logic rst, input logic [5:0] ctl,
                              input logic [31:0] imm, input logic ret);
    row_t r;
    r.instr = instr; r.valid = valid; r.rs1 = rs1; r.ready = ready;
    r.rst = rst; r.ctl = ctl; r.imm = imm; r.ret = ret;
    return r;
  endfunction

  function automatic obs_t sample();
    return {io_stall_en, io_jal_en, io_jalr_en, io_mem_req, io_mem_err, io_halted,
            io_imm, io_rs1, io_instret};
  endfunction

  // drive one cycle of stimulus and queue what the DUT must show during it
  task automatic drive_and_push(input row_t r);
    @(posedge clock);
    #1;
    reset          = r.rst;
    io_instr       = r.instr;
    io_instr_valid = r.valid;
    io_rs1_data    = r.rs1;
    io_mem_ready   = r.ready;
    exp_q.push_back({r.ctl, r.imm, r.rs1, m_instret});
    m_instret = r.rst ? 32'd0 : m_instret + {31'd0, r.ret};
  endtask

  task automatic test_reset();
    row_t rows[$];
    obs_t got, want;
    rows.push_back(mk(JAL8, 1, 32'h55, 1, 1, C_STALL, 32'd8, 0));
    rows.push_back(mk(LW,   1, 32'h0,  0, 1, C_STALL, 32'd0, 0));
    rows.push_back(mk(ADDI, 0, 32'h0,  0, 1, C_STALL, 32'd0, 0));
    foreach (rows[i]) begin
      drive_and_push(rows[i]);
      @(negedge clock);
      got = sample(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_err++; $display("FAIL reset[%0d] got=%h want=%h", i, got, want);
      end
    end
  endtask

  task automatic test_sequential();
    row_t rows[$];
    obs_t got, want;
    for (int k = 0; k < 3; k++) rows.push_back(mk(ADDI, 1, 32'h0, 0, 0, C_NONE, 32'd0, 1));
    rows.push_back(mk(ADDI,  0, 32'h0, 0, 0, C_STALL, 32'd0, 0));
    rows.push_back(mk(CSRRW, 1, 32'h0, 0, 0, C_NONE,  32'd0, 1));
    rows.push_back(mk(ADDI,  0, 32'h0, 1, 0, C_STALL, 32'd0, 0));
    foreach (rows[i]) begin
      drive_and_push(rows[i]);
      @(negedge clock);
      got = sample(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_err++; $display("FAIL sequential[%0d] got=%h want=%h", i, got, want);
      end
    end
  endtask

  task automatic test_jumps();
    row_t rows[$];
    obs_t got, want;
    rows.push_back(mk(JAL8,  1, 32'h0,   0, 0, C_NONE | C_JAL,  32'd8,        1));
    rows.push_back(mk(JAL8,  0, 32'h0,   0, 0, C_STALL,         32'd8,        0));
    rows.push_back(mk(JALR,  1, 32'h100, 0, 0, C_NONE | C_JALR, 32'hFFFFFFFC, 1));
    rows.push_back(mk(JALM4, 1, 32'h0,   0, 0, C_NONE | C_JAL,  32'hFFFFFFFC, 1));
    rows.push_back(mk(JALR1, 1, 32'h203, 0, 0, C_NONE | C_JALR, 32'h00000001, 1));
    foreach (rows[i]) begin
      drive_and_push(rows[i]);
      @(negedge clock);
      got = sample(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_err++; $display("FAIL jumps[%0d] got=%h want=%h", i, got, want);
      end
    end
  endtask

  task automatic test_load_store();
    row_t rows[$];
    obs_t got, want;
    // ready on the decode cycle must be ignored
    rows.push_back(mk(LW, 1, 32'h0, 1, 0, C_STALL | C_REQ, 32'd0, 0));
    rows.push_back(mk(LW, 1, 32'h0, 0, 0, C_STALL,         32'd0, 0));
    rows.push_back(mk(LW, 1, 32'h0, 0, 0, C_STALL,         32'd0, 0));
    rows.push_back(mk(LW, 1, 32'h0, 1, 0, C_NONE,          32'd0, 1));
    rows.push_back(mk(SW, 1, 32'h0, 0, 0, C_STALL | C_REQ, 32'd0, 0));
    rows.push_back(mk(SW, 1, 32'h0, 1, 0, C_NONE,          32'd0, 1));
    rows.push_back(mk(ADDI, 1, 32'h0, 0, 0, C_NONE,        32'd0, 1));
    foreach (rows[i]) begin
      drive_and_push(rows[i]);
      @(negedge clock);
      got = sample(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_err++; $display("FAIL load_store[%0d] got=%h want=%h", i, got, want);
      end
    end
  endtask

  task automatic test_timeout();
    row_t rows[$];
    obs_t got, want;
    rows.push_back(mk(LW, 1, 32'h0, 0, 0, C_STALL | C_REQ, 32'd0, 0));
    for (int k = 0; k < 14; k++) rows.push_back(mk(LW, 1, 32'h0, 0, 0, C_STALL, 32'd0, 0));
    rows.push_back(mk(LW, 1, 32'h0, 0, 0, C_ERR, 32'd0, 0));
    rows.push_back(mk(ADDI, 1, 32'h0, 0, 0, C_NONE, 32'd0, 1));
    // ready arriving on the timeout cycle completes instead of erroring
    rows.push_back(mk(SW, 1, 32'h0, 0, 0, C_STALL | C_REQ, 32'd0, 0));
    for (int k = 0; k < 14; k++) rows.push_back(mk(SW, 1, 32'h0, 0, 0, C_STALL, 32'd0, 0));
    rows.push_back(mk(SW, 1, 32'h0, 1, 0, C_NONE, 32'd0, 1));
    foreach (rows[i]) begin
      drive_and_push(rows[i]);
      @(negedge clock);
      got = sample(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_err++; $display("FAIL timeout[%0d] got=%h want=%h", i, got, want);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    row_t rows[$];
    obs_t got, want;
    rows.push_back(mk(ADDI, 1, 32'h0, 0, 0, C_NONE,          32'd0, 1));
    rows.push_back(mk(LW,   1, 32'h0, 0, 0, C_STALL | C_REQ, 32'd0, 0));
    rows.push_back(mk(LW,   1, 32'h0, 0, 0, C_STALL,         32'd0, 0));
    rows.push_back(mk(LW,   1, 32'h0, 0, 1, C_STALL,         32'd0, 0));
    rows.push_back(mk(ADDI, 1, 32'h0, 1, 0, C_NONE,          32'd0, 1));
    foreach (rows[i]) begin
      drive_and_push(rows[i]);
      @(negedge clock);
      got = sample(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_err++; $display("FAIL reset_mid_wait[%0d] got=%h want=%h", i, got, want);
      end
    end
  endtask

  task automatic test_halt();
    row_t rows[$];
    obs_t got, want;
    rows.push_back(mk(ADDI,  1, 32'h0, 0, 0, C_NONE,  32'd0, 1));
    rows.push_back(mk(ECALL, 1, 32'h0, 0, 0, C_STALL, 32'd0, 0));
    for (int k = 0; k < 20; k++)
      rows.push_back(mk(JAL8, 1, 32'h0, 1, 0, C_STALL | C_HALT, 32'd8, 0));
    rows.push_back(mk(LW,   1, 32'h0, 0, 1, C_STALL, 32'd0, 0));
    rows.push_back(mk(ADDI, 0, 32'h0, 0, 0, C_STALL, 32'd0, 0));
    rows.push_back(mk(ADDI, 1, 32'h0, 0, 0, C_NONE,  32'd0, 1));
    foreach (rows[i]) begin
      drive_and_push(rows[i]);
      @(negedge clock);
      got = sample(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_err++; $display("FAIL halt[%0d] got=%h want=%h", i, got, want);
      end
    end
  endtask

  initial begin
    n_cmp          = 0;
    n_err          = 0;
    m_instret      = 32'd0;
    reset          = 1'b1;
    io_instr       = 32'd0;
    io_instr_valid = 1'b0;
    io_rs1_data    = 32'd0;
    io_mem_ready   = 1'b0;
    repeat (2) @(posedge clock);
    test_reset();
    test_sequential();
    test_jumps();
    test_load_store();
    test_timeout();
    test_reset_mid_wait();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_control.md
FETCH_CONTROL -- requirements
Module: fetch_control

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, maximum MEM_WAIT cycles before abort (range 1..15).
REQ-002 SHALL have ports: clock  in  1  rising-edge clock; reset  in  1  synchronous, active-high reset.
REQ-003 io_instr  in  32  instruction at the current fetch PC (combinational instruction memory, same cycle).
REQ-004 io_instr_valid  in  1  io_instr is valid this cycle.
REQ-005 io_rs1_data  in  32  register-file read of io_instr[19:15], same cycle.
REQ-006 io_mem_ready  in  1  data-memory completion for the outstanding load/store.
REQ-007 io_imm  out  32  sign-extended immediate to the fetch unit.
REQ-008 io_rs1  out  32  rs1 operand to the fetch unit, equals io_rs1_data.
REQ-009 io_jal_en, io_jalr_en, io_stall_en  out  1 each  fetch-unit controls.
REQ-010 io_mem_req  out  1  one-cycle data-memory request pulse.
REQ-011 io_mem_err  out  1  one-cycle timeout pulse.
REQ-012 io_halted  out  1  block is in HALT.
REQ-013 io_instret  out  32  retired-instruction count.

Function
REQ-014 Decode by opcode io_instr[6:0]:
- JAL = 1101111
- JALR = 1100111
- LOAD = 0000011
- STORE = 0100011
- SYS = 1110011 with funct3 = 000 (ECALL/EBREAK)
- any other opcode is sequential.
REQ-015 io_imm:
- JAL: J-type {instr[31] x12, instr[19:12], instr[20], instr[30:21], 0}
- JALR: I-type sign-extended instr[31:20]
- all other opcodes: 0.
REQ-016 JALR target LSB is not cleared; the target is exactly rs1+imm.
REQ-017 State machine has states RUN, MEM_WAIT and HALT; io_jal_en, io_jalr_en, io_stall_en, io_mem_req and io_mem_err are combinational from state and inputs.
REQ-018 RUN with io_instr_valid=0: io_stall_en=1, all other controls 0, stay in RUN.
REQ-019 RUN, valid, JAL: io_jal_en=1, io_stall_en=0, stay in RUN.
REQ-020 RUN, valid, JALR: io_jalr_en=1, io_stall_en=0, stay in RUN.
REQ-021 RUN, valid, LOAD/STORE: io_mem_req=1, io_stall_en=1, next state MEM_WAIT, wait counter cleared to 0; io_mem_ready is ignored in this cycle.
REQ-022 RUN, valid, SYS: io_stall_en=1, next state HALT.
REQ-023 RUN, valid, any other opcode: all controls 0, so the PC advances by 4.
REQ-024 MEM_WAIT with io_mem_ready=1: io_stall_en=0, next state RUN.
REQ-025 MEM_WAIT with io_mem_ready=0 and counter = MEM_TIMEOUT-1: io_mem_err=1, io_stall_en=0, next state RUN (the instruction is skipped).
REQ-026 MEM_WAIT otherwise: io_stall_en=1, counter increments, stay in MEM_WAIT.
REQ-027 io_mem_ready=1 on the same cycle as the timeout takes priority: completion, with no io_mem_err.
REQ-028 HALT: io_stall_en=1 and all other controls 0 in every cycle; only reset exits HALT.
REQ-029 io_instret increments by 1, wrapping 2^32-1 to 0, on:
- every RUN valid cycle that is JAL, JALR or sequential
- every MEM_WAIT completion cycle.
REQ-030 io_instret does not increment on timeout, SYS, or invalid cycles.
REQ-031 A SYS instruction is not counted.
REQ-032 At most one of io_jal_en and io_jalr_en is high in any cycle.
REQ-033 io_jal_en, io_jalr_en and io_mem_req are never high outside RUN.

Reset
REQ-034 On a clock edge with reset=1: state <= RUN, wait counter <= 0, io_instret <= 0.
REQ-035 While reset=1, outputs are forced:
- io_stall_en=1
- io_jal_en, io_jalr_en, io_mem_req, io_mem_err = 0
- io_halted=0.
REQ-036 Reset asserted mid-MEM_WAIT or in HALT aborts to RUN with no io_mem_err pulse.

Verification
REQ-037 Reset then valid ADDI stream of 3 -> stall_en=0 on each cycle, instret=3.
REQ-038 JAL with instr=0x0080006F -> imm=8, jal_en=1 for one cycle.
REQ-039 JALR instr=0xFFC08067, rs1_data=0x100 -> imm=0xFFFFFFFC, jalr_en=1, io_rs1=0x100.
REQ-040 LOAD followed by mem_ready high 3 cycles later -> the sequence below, instret +1:
- mem_req pulses 1 cycle
- stall_en=1 for 3 cycles
- stall_en=0 on the ready cycle.
REQ-041 LOAD with mem_ready never asserted (MEM_TIMEOUT=15) -> the sequence below, instret unchanged:
- stall_en=1 for 15 cycles total (the RUN decode cycle plus 14 MEM_WAIT cycles)
- mem_err pulse with stall_en=0 on the 15th MEM_WAIT cycle.
REQ-042 ECALL 0x00000073 -> halted=1 and stall_en=1 held for 20 cycles; reset -> halted=0, instret=0.
